// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file write path: width of a register
// select, the hard-wired zero register, and the default data width.
// No ports (package).
// ---------------------------------------------------------------------------
package regfile_pkg;

   // A register select is always 5 bits wide, whatever REGSIZE is set to
   localparam int REG_SEL_W = 5;

   // Register 0 reads as zero, so writes to it are dropped
   localparam logic [REG_SEL_W-1:0] REG_ZERO = 5'd0;

   // Default data width, matching the register file word
   localparam int DEFAULT_BITSIZE = 32;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. It scans req starting at ptr,
// wraps modulo NREQ, and grants the first requester it finds.
// Ports:
//   req        in   NREQ   request vector
//   ptr        in   IDXW   index with the highest priority this cycle
//   grant      out  NREQ   one-hot grant (all zero when nothing requests)
//   grantIdx   out  IDXW   binary index of the granted requester
//   grantValid out  1      some requester was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IDXW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] grantIdx,
   output logic            grantValid
);

   // Walk the requesters in priority order, starting at ptr. Once one is
   // granted the rest of the walk is ignored, which keeps the grant one-hot.
   always_comb begin
      logic [IDXW-1:0] idx;
      grant      = '0;
      grantIdx   = '0;
      grantValid = 1'b0;
      idx        = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDXW'((int'(ptr) + k) % NREQ);
         if (!grantValid && req[idx]) begin
            grant[idx] = 1'b1;
            grantIdx   = idx;
            grantValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register file write port between NREQ writeback
// sources. It uses round-robin arbitration with a valid/ready handshake, and
// keeps a per-register pending-write scoreboard so decode can stall on RAW
// hazards.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_valid/req_sel/req_data    packed per-requester write requests
//   req_ready                     one-hot grant (combinational)
//   reserve_valid/reserve_sel     decode marks a destination as pending
//   rd_sel1/rd_sel2               decode source registers
//   hazard1/hazard2               source has a pending write (combinational)
//   rf_write_select/data/enable   registered register file write port
// ---------------------------------------------------------------------------
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int BITSIZE = DEFAULT_BITSIZE,
   parameter int NREQ    = 3,
   parameter int REGSIZE = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [REG_SEL_W*NREQ-1:0] req_sel,
   input  logic [BITSIZE*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      reserve_valid,
   input  logic [REG_SEL_W-1:0]      reserve_sel,
   input  logic [REG_SEL_W-1:0]      rd_sel1,
   input  logic [REG_SEL_W-1:0]      rd_sel2,
   output logic                      hazard1,
   output logic                      hazard2,
   output logic [REG_SEL_W-1:0]      rf_write_select,
   output logic [BITSIZE-1:0]        rf_write_data,
   output logic                      rf_write_enable
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDXW-1:0]      rrPtr;
   logic [IDXW-1:0]      rrPtrNext;
   logic [NREQ-1:0]      arbGrant;
   logic [IDXW-1:0]      arbGrantIdx;
   logic                 arbGrantValid;
   logic                 transfer;
   logic [REG_SEL_W-1:0] grantedSel;
   logic [BITSIZE-1:0]   grantedData;
   logic [REGSIZE-1:0]   busy;
   logic [REGSIZE-1:0]   busyNext;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) uArbiter (
      .req        (req_valid),
      .ptr        (rrPtr),
      .grant      (arbGrant),
      .grantIdx   (arbGrantIdx),
      .grantValid (arbGrantValid)
   );

   // Reset suppresses every grant, so nothing is accepted in a cycle whose
   // edge would discard it anyway. Every grant then becomes a transfer,
   // because the arbiter only grants requesters whose valid is high.
   always_comb begin
      req_ready = reset ? '0 : arbGrant;
      transfer  = arbGrantValid && !reset;
   end

   // Select the winning requester's destination and data. The one-hot grant
   // drives the mux so there is no multiply on the index path.
   always_comb begin
      grantedSel  = '0;
      grantedData = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arbGrant[i]) begin
            grantedSel  = req_sel[i*REG_SEL_W +: REG_SEL_W];
            grantedData = req_data[i*BITSIZE +: BITSIZE];
         end
      end
   end

   // After a grant, priority moves to the requester just past the winner
   // and wraps at NREQ-1. This is what makes the arbitration fair.
   always_comb begin
      rrPtrNext = (arbGrantIdx == IDXW'(NREQ - 1)) ? '0 : arbGrantIdx + 1'b1;
   end

   // Scoreboard update. The clear for the write now leaving the output
   // register is applied first, so a reservation of the same register on the
   // same edge wins: that reservation is a newer producer still in flight.
   always_comb begin
      busyNext = busy;
      if (rf_write_enable) begin
         busyNext[rf_write_select] = 1'b0;
      end
      if (reserve_valid && (reserve_sel != REG_ZERO)) begin
         busyNext[reserve_sel] = 1'b1;
      end
   end

   // Output register, round-robin pointer and scoreboard state. A transfer
   // to register 0 is still accepted and advances the pointer, but it never
   // raises the write enable, so the scoreboard is not disturbed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_enable <= 1'b0;
         rf_write_select <= REG_ZERO;
         rf_write_data   <= '0;
         rrPtr           <= '0;
         busy            <= '0;
      end else begin
         busy <= busyNext;
         if (transfer) begin
            rf_write_select <= grantedSel;
            rf_write_data   <= grantedData;
            rf_write_enable <= (grantedSel != REG_ZERO);
            rrPtr           <= rrPtrNext;
         end else begin
            rf_write_enable <= 1'b0;
         end
      end
   end

   // Hazard lookup. There is no bypass from the output register, so a source
   // stays hazardous until the register file itself holds the value.
   always_comb begin
      hazard1 = !reset && (rd_sel1 != REG_ZERO) && busy[rd_sel1];
      hazard2 = !reset && (rd_sel2 != REG_ZERO) && busy[rd_sel2];
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Directed scenarios with literal expectations, followed by randomized
// traffic checked every cycle against a behavioural model of the arbiter and
// scoreboard.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int NREQ    = 3;
   localparam int BITSIZE = 32;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NREQ-1:0]         reqValid;
   logic [5*NREQ-1:0]       reqSel;
   logic [BITSIZE*NREQ-1:0] reqData;
   logic [NREQ-1:0]         reqReady;
   logic                    reserveValid;
   logic [4:0]              reserveSel;
   logic [4:0]              rdSel1;
   logic [4:0]              rdSel2;
   logic                    hazard1;
   logic                    hazard2;
   logic [4:0]              rfSel;
   logic [BITSIZE-1:0]      rfData;
   logic                    rfWe;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   int               mPtr       = 0;
   bit               mBusy[32];
   bit               mWe        = 1'b0;
   logic [4:0]       mSel       = '0;
   logic [31:0]      mData      = '0;
   int               mLastGrant = -1;

   regfile_write_arbiter #(
      .BITSIZE (BITSIZE),
      .NREQ    (NREQ),
      .REGSIZE (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (reqValid),
      .req_sel         (reqSel),
      .req_data        (reqData),
      .req_ready       (reqReady),
      .reserve_valid   (reserveValid),
      .reserve_sel     (reserveSel),
      .rd_sel1         (rdSel1),
      .rd_sel2         (rdSel2),
      .hazard1         (hazard1),
      .hazard2         (hazard2),
      .rf_write_select (rfSel),
      .rf_write_data   (rfData),
      .rf_write_enable (rfWe)
   );

   // Free-running clock, first rising edge at t=5
   always #5 clk = ~clk;

   // First valid requester found scanning from ptr, wrapping; -1 if none
   function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [2:0] v, input logic [14:0] s,
                                input logic [95:0] d, input logic rv,
                                input logic [4:0] rs, input logic [4:0] r1,
                                input logic [4:0] r2);
      reqValid     = v;
      reqSel       = s;
      reqData      = d;
      reserveValid = rv;
      reserveSel   = rs;
      rdSel1       = r1;
      rdSel2       = r2;
   endtask

   // Model step on every rising edge: what each edge does, stated directly
   // from the behavioural rules rather than from the RTL's structure
   always @(posedge clk) begin : modelStep
      int g;
      g = pickGrant(reqValid, mPtr);
      if (reset) begin
         mPtr = 0;
         for (int r = 0; r < 32; r++) mBusy[r] = 1'b0;
         mWe        = 1'b0;
         mSel       = '0;
         mData      = '0;
         mLastGrant = -1;
      end else begin
         if (mWe) mBusy[mSel] = 1'b0;
         if (reserveValid && reserveSel != 5'd0) mBusy[reserveSel] = 1'b1;
         mLastGrant = g;
         if (g >= 0) begin
            mSel  = reqSel[g*5 +: 5];
            mData = reqData[g*BITSIZE +: BITSIZE];
            mWe   = (mSel != 5'd0);
            mPtr  = (g + 1) % NREQ;
         end else begin
            mWe = 1'b0;
         end
      end
   end

   // Compare every output against the model on each falling edge, well away
   // from the edge that updates the DUT
   always @(negedge clk) begin : compareStep
      int g;
      logic [NREQ-1:0] expReady;
      logic expH1;
      logic expH2;
      g = pickGrant(reqValid, mPtr);
      expReady = '0;
      if (!reset && g >= 0) expReady[g] = 1'b1;
      expH1 = !reset && rdSel1 != 5'd0 && mBusy[rdSel1];
      expH2 = !reset && rdSel2 != 5'd0 && mBusy[rdSel2];
      checkOutput("model req_ready", 32'(reqReady), 32'(expReady));
      checkOutput("model hazard1", 32'(hazard1), 32'(expH1));
      checkOutput("model hazard2", 32'(hazard2), 32'(expH2));
      checkOutput("model rf_write_enable", 32'(rfWe), 32'(mWe));
      checkOutput("model rf_write_select", 32'(rfSel), 32'(mSel));
      checkOutput("model rf_write_data", rfData, mData);
   end

   // Directed scenarios with literal expectations, then randomized traffic
   initial begin
      reset = 1'b1;
      applyStimulus(3'b111, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      tick();
      #1;
      checkOutput("reset req_ready", 32'(reqReady), 32'd0);
      checkOutput("reset rf_write_enable", 32'(rfWe), 32'd0);
      checkOutput("reset rf_write_select", 32'(rfSel), 32'd0);
      checkOutput("reset rf_write_data", rfData, 32'd0);

      // Single write
      reset = 1'b0;
      applyStimulus(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF},
                    1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("single ready", 32'(reqReady), 32'b001);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("single we", 32'(rfWe), 32'd1);
      checkOutput("single select", 32'(rfSel), 32'd5);
      checkOutput("single data", rfData, 32'hDEADBEEF);

      // Fairness from rr_ptr=0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      applyStimulus(3'b111, {5'd12, 5'd11, 5'd10}, {32'h2, 32'h1, 32'h0},
                    1'b0, 5'd0, 5'd0, 5'd0);
      for (int k = 0; k < 6; k++) begin
         logic [2:0] expOneHot;
         expOneHot = 3'b001 << (k % 3);
         #1;
         checkOutput("fair grant", 32'(reqReady), 32'(expOneHot));
         if (k > 0) begin
            checkOutput("fair no bubble", 32'(rfWe), 32'd1);
            checkOutput("fair select", 32'(rfSel), 32'(10 + ((k - 1) % 3)));
         end
         tick();
      end
      #1;
      checkOutput("fair last select", 32'(rfSel), 32'd12);
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
      tick();

      // Stall-hold: requester 1 waits one cycle holding sel/data
      applyStimulus(3'b011, {5'd0, 5'd21, 5'd20}, {32'h0, 32'hB1, 32'hA0},
                    1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("stall first grant", 32'(reqReady), 32'b001);
      tick();
      applyStimulus(3'b010, {5'd0, 5'd21, 5'd20}, {32'h0, 32'hB1, 32'hA0},
                    1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("stall second grant", 32'(reqReady), 32'b010);
      checkOutput("stall first select", 32'(rfSel), 32'd20);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("stall held we", 32'(rfWe), 32'd1);
      checkOutput("stall held select", 32'(rfSel), 32'd21);
      checkOutput("stall held data", rfData, 32'hB1);

      // Scoreboard on r7
      applyStimulus(3'b000, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
      #1;
      checkOutput("sb r7 before set", 32'(hazard1), 32'd0);
      tick();
      applyStimulus(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77},
                    1'b0, 5'd0, 5'd7, 5'd0);
      #1;
      checkOutput("sb r7 hazard1", 32'(hazard1), 32'd1);
      checkOutput("sb r0 hazard2", 32'(hazard2), 32'd0);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd7, 5'd0);
      #1;
      checkOutput("sb r7 write we", 32'(rfWe), 32'd1);
      checkOutput("sb r7 write select", 32'(rfSel), 32'd7);
      checkOutput("sb r7 still busy", 32'(hazard1), 32'd1);
      tick();
      #1;
      checkOutput("sb r7 cleared", 32'(hazard1), 32'd0);

      // Set/clear collision on r9
      applyStimulus(3'b000, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
      tick();
      applyStimulus(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99},
                    1'b0, 5'd0, 5'd9, 5'd0);
      #1;
      checkOutput("coll r9 reserved", 32'(hazard1), 32'd1);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
      #1;
      checkOutput("coll r9 write we", 32'(rfWe), 32'd1);
      checkOutput("coll r9 write select", 32'(rfSel), 32'd9);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd9, 5'd0);
      #1;
      checkOutput("coll set wins", 32'(hazard1), 32'd1);
      tick();
      #1;
      checkOutput("coll still busy", 32'(hazard1), 32'd1);

      // Reset on the grant edge (rr_ptr is 1 here, after the r9 grant)
      applyStimulus(3'b011, {5'd0, 5'd3, 5'd4}, {32'h0, 32'h33, 32'h44},
                    1'b0, 5'd0, 5'd9, 5'd0);
      reset = 1'b1;
      #1;
      checkOutput("rst no grant", 32'(reqReady), 32'd0);
      checkOutput("rst hazard1", 32'(hazard1), 32'd0);
      tick();
      reset = 1'b0;
      applyStimulus(3'b111, {5'd2, 5'd3, 5'd4}, {32'h22, 32'h33, 32'h44},
                    1'b0, 5'd0, 5'd9, 5'd0);
      #1;
      checkOutput("rst squashed we", 32'(rfWe), 32'd0);
      checkOutput("rst busy cleared", 32'(hazard1), 32'd0);
      checkOutput("rst ptr zero", 32'(reqReady), 32'b001);
      tick();
      applyStimulus(3'b000, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      checkOutput("rst next write select", 32'(rfSel), 32'd4);

      // Randomized traffic: pending requests hold sel/data until granted,
      // with occasional withdrawal and occasional reset pulses
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         reset = ($urandom_range(99) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!(reqValid[i] && mLastGrant != i && $urandom_range(9) != 0)) begin
               reqValid[i]                  = ($urandom_range(9) < 6);
               reqSel[i*5 +: 5]             = 5'($urandom_range(11));
               reqData[i*BITSIZE +: BITSIZE] = $urandom;
            end
         end
         reserveValid = ($urandom_range(9) < 4);
         reserveSel   = 5'($urandom_range(11));
         rdSel1       = 5'($urandom_range(11));
         rdSel2       = 5'($urandom_range(11));
      end
      tick();
      #4;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
